// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor driving a 1-bit full-subtraction cell, LSB first
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh;
  logic brw;
  logic [CW-1:0] cnt;
  logic d, bo, last;
  assign d = a_sh[0] ^ b_sh[0] ^ brw;
  assign bo = (~a_sh[0] & b_sh[0]) | ((~a_sh[0] | b_sh[0]) & brw);
  assign last = cnt == CW'(WIDTH - 1);
  assign ready = state != RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      brw <= 1'b0;
      cnt <= '0;
      diff_out <= '0;
      bout_out <= 1'b0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= {d, d_sh[WIDTH-1:1]};
      brw <= bo;
      cnt <= cnt + CW'(1);
      if (last) begin
        state <= DONE;
        diff_out <= {d, d_sh[WIDTH-1:1]};
        bout_out <= bo;
      end
    end else if (start) begin
      state <= RUN;
      a_sh <= a_in;
      b_sh <= b_in;
      brw <= bin_in;
      d_sh <= '0;
      cnt <= '0;
    end else
      state <= IDLE;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors, handshake corner cases and random checks at WIDTH 8 and 16
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1, s8 = 1'b0, s16 = 1'b0, bin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic r8, bz8, dn8, bo8, r16, bz16, dn16, bo16;
  logic [7:0] d8;
  logic [15:0] d16;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(s8), .a_in(a[7:0]), .b_in(b[7:0]),
    .bin_in(bin), .ready(r8), .busy(bz8), .done(dn8), .diff_out(d8), .bout_out(bo8));
  serial_subtractor #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start(s16), .a_in(a), .b_in(b),
    .bin_in(bin), .ready(r16), .busy(bz16), .done(dn16), .diff_out(d16), .bout_out(bo16));
  typedef struct {
    logic [7:0] a, b;
    logic bin;
    logic [7:0] d;
    logic bo;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input bit w, input logic [15:0] av, input logic [15:0] bv, input logic bi, output int n);
    a = av;
    b = bv;
    bin = bi;
    chk("ready_before_start", w ? r16 : r8, 1);
    if (w) s16 = 1'b1; else s8 = 1'b1;
    tick;
    s8 = 1'b0;
    s16 = 1'b0;
    n = 1;
    chk("busy_after_accept", w ? bz16 : bz8, 1);
    chk("done_low_after_accept", w ? dn16 : dn8, 0);
    while (!(w ? dn16 : dn8) && n < 40) begin
      tick;
      n++;
      if (!(w ? dn16 : dn8)) chk("busy_in_run", w ? bz16 : bz8, 1);
    end
  endtask
  initial begin
    int n, dones;
    logic [7:0] prev;
    logic [8:0] e9;
    logic [16:0] e17;
    logic [15:0] ra, rb;
    logic rbi;
    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vt[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vt[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vt[5] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    vt[6] = '{8'h33, 8'h22, 1'b0, 8'h11, 1'b0};
    vt[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vt[8] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
    vt[9] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vt[10] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0};
    vt[11] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1};
    tick;
    tick;
    rst = 1'b0;
    chk("reset_ready", r8, 1);
    chk("reset_busy", bz8, 0);
    chk("reset_done", dn8, 0);
    chk("reset_diff", d8, 8'h00);
    chk("reset_bout", bo8, 0);
    chk("reset_ready16", r16, 1);
    chk("reset_diff16", d16, 16'h0);
    for (int i = 0; i < 12; i++) begin
      op(0, {8'h0, vt[i].a}, {8'h0, vt[i].b}, vt[i].bin, n);
      chk("vec_latency", n, 9);
      chk("vec_diff", d8, vt[i].d);
      chk("vec_bout", bo8, vt[i].bo);
      repeat (i % 2) tick;
    end
    tick;
    a = 16'h80;
    b = 16'h01;
    bin = 1'b0;
    s8 = 1'b1;
    tick;
    s8 = 1'b0;
    tick;
    tick;
    a = 16'h11;
    b = 16'h11;
    bin = 1'b1;
    s8 = 1'b1;
    tick;
    s8 = 1'b0;
    chk("ignored_start_busy", bz8, 1);
    a = 16'hC3;
    b = 16'h5E;
    n = 4;
    dones = 0;
    while (!dn8 && n < 40) begin
      tick;
      n++;
    end
    chk("ignored_latency", n, 9);
    chk("ignored_diff", d8, 8'h7F);
    chk("ignored_bout", bo8, 0);
    for (int i = 0; i < 15; i++) begin
      dones += int'(dn8);
      tick;
    end
    chk("ignored_one_done", dones, 1);
    op(0, 16'h0, 16'h1, 1'b0, n);
    prev = d8;
    a = 16'h10;
    b = 16'h20;
    bin = 1'b0;
    s8 = 1'b1;
    tick;
    s8 = 1'b0;
    chk("b2b_no_idle", r8, 0);
    n = 1;
    while (!dn8 && n < 40) begin
      chk("b2b_diff_held", d8, prev);
      tick;
      n++;
    end
    chk("b2b_latency", n, 9);
    chk("b2b_diff", d8, 8'hF0);
    chk("b2b_bout", bo8, 1);
    tick;
    a = 16'h33;
    b = 16'h22;
    s8 = 1'b1;
    tick;
    s8 = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_ready", r8, 1);
    chk("abort_busy", bz8, 0);
    chk("abort_diff", d8, 8'h00);
    chk("abort_bout", bo8, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      dones += int'(dn8);
      tick;
    end
    chk("abort_no_done", dones, 0);
    op(0, 16'h33, 16'h22, 1'b0, n);
    chk("fresh_latency", n, 9);
    chk("fresh_diff", d8, 8'h11);
    chk("fresh_bout", bo8, 0);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbi = 1'($urandom);
      op(0, ra, rb, rbi, n);
      e9 = {1'b0, ra[7:0]} - {1'b0, rb[7:0]} - {8'h0, rbi};
      chk("rnd8_latency", n, 9);
      chk("rnd8_diff", d8, e9[7:0]);
      chk("rnd8_bout", bo8, e9[8]);
      repeat ($urandom_range(0, 2)) tick;
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbi = 1'($urandom);
      op(1, ra, rb, rbi, n);
      e17 = {1'b0, ra} - {1'b0, rb} - {16'h0, rbi};
      chk("rnd16_latency", n, 17);
      chk("rnd16_diff", d16, e17[15:0]);
      chk("rnd16_bout", bo16, e17[16]);
      repeat ($urandom_range(0, 2)) tick;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
